// File: rtl/data_memory_responder.sv
// Line-oriented data memory with a fixed request-to-ack latency.
// Handshake: one request is latched in IDLE, then WAIT counts, then ACK gives a one-cycle completion pulse.
module data_memory_responder #(
    parameter int LATENCY = 10,
    parameter int DEPTH   = 512
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    input  logic         enable_i,
    input  logic         write_i,
    output logic         ack_o,
    output logic [255:0] data_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] CNT_LAST = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [255:0]       wdata_q, wdata_d;
    logic               write_q, write_d;
    logic               ack_q, ack_d;
    logic [255:0]       rdata_q, rdata_d;
    logic               mem_we_s;
    logic               enter_ack_s;
    logic               unused_addr_s;

    logic [255:0]       mem_q [DEPTH];

    // Only the line-index bits matter; offset and upper bits alias by design.
    assign unused_addr_s = ^{addr_i[31:IDX_W+5], addr_i[4:0]};

    // State, counter, latched request and registered outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            idx_q   <= '0;
            wdata_q <= 256'd0;
            write_q <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= 256'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state: inputs are sampled only in IDLE, so a request cannot be cancelled.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        write_d = write_q;
        case (state_q)
            ST_IDLE: begin
                if (enable_i) begin
                    idx_d   = addr_i[5 +: IDX_W];
                    wdata_d = data_i;
                    write_d = write_i;
                    cnt_d   = 8'd0;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_ACK;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                    state_d = ST_WAIT;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs: the memory access happens on the edge that enters ACK.
    always_comb begin
        enter_ack_s = (state_q == ST_WAIT) && (state_d == ST_ACK);
        ack_d       = enter_ack_s;
        mem_we_s    = enter_ack_s && write_q;
        if (enter_ack_s && !write_q) begin
            rdata_d = mem_q[idx_q];
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Line storage; deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (mem_we_s) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign ack_o  = ack_q;
    assign data_o = rdata_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: table of line requests plus reset and LATENCY=1 sequences.
module tb_data_memory_responder;

    logic         clk;
    logic         rst_n;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic         en;
    logic         wr;
    logic         ack;
    logic [255:0] dout;

    logic [31:0]  addr1;
    logic [255:0] wdata1;
    logic         en1;
    logic         wr1;
    logic         ack1;
    logic [255:0] dout1;

    int checks;
    int failures;

    data_memory_responder #(.LATENCY(10), .DEPTH(512)) dut (
        .clk_i(clk), .rst_i(rst_n), .addr_i(addr), .data_i(wdata),
        .enable_i(en), .write_i(wr), .ack_o(ack), .data_o(dout)
    );

    data_memory_responder #(.LATENCY(1), .DEPTH(512)) dut1 (
        .clk_i(clk), .rst_i(rst_n), .addr_i(addr1), .data_i(wdata1),
        .enable_i(en1), .write_i(wr1), .ack_o(ack1), .data_o(dout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        logic         drop;
        logic [255:0] exp_dout;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One request on the LATENCY=10 instance; optionally drop enable and scramble inputs during WAIT.
    task automatic run_req(input string name, input logic w, input logic [31:0] a,
                           input logic [255:0] d, input logic drop, input logic [255:0] exp_dout);
        int  n;
        bit  got;
        @(negedge clk);
        en = 1'b1; wr = w; addr = a; wdata = d;
        @(posedge clk); #1;
        if (drop) begin
            en    = 1'b0;
            addr  = a ^ 32'h0000_0020;
            wdata = ~d;
            wr    = ~w;
        end
        n = 0;
        got = 1'b0;
        for (int k = 1; k <= 300 && !got; k++) begin
            @(posedge clk); #1;
            if (ack) begin
                got = 1'b1;
                n = k;
            end
        end
        check({name, "_latency"}, 256'(n), 256'd10);
        check({name, "_data"}, dout, exp_dout);
        en = 1'b0;
        @(posedge clk); #1;
        check({name, "_ack_width"}, 256'(ack), 256'd0);
    endtask

    initial begin
        int last;
        int acks;
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        en = 1'b0; wr = 1'b0; addr = 32'd0; wdata = 256'd0;
        en1 = 1'b0; wr1 = 1'b0; addr1 = 32'd0; wdata1 = 256'd0;

        vecs[0] = '{1'b1, 32'h0000_0060, {32{8'hA5}}, 1'b0, 256'd0};
        vecs[1] = '{1'b0, 32'h0000_0060, 256'd0,       1'b0, {32{8'hA5}}};
        vecs[2] = '{1'b1, 32'h0000_0040, 256'h1234,    1'b0, {32{8'hA5}}};
        vecs[3] = '{1'b0, 32'h0000_005F, 256'd0,       1'b0, 256'h1234};
        vecs[4] = '{1'b1, 32'h0000_0020, 256'hBEEF,    1'b0, 256'h1234};
        vecs[5] = '{1'b0, 32'h0000_4020, 256'd0,       1'b0, 256'hBEEF};
        vecs[6] = '{1'b0, 32'h0000_0060, 256'd0,       1'b1, {32{8'hA5}}};
        vecs[7] = '{1'b1, 32'h0000_00E0, 256'h77,      1'b0, {32{8'hA5}}};
        vecs[8] = '{1'b0, 32'h0000_00E0, 256'd0,       1'b0, 256'h77};

        repeat (2) @(posedge clk);
        #1;
        check("reset_ack", 256'(ack), 256'd0);
        check("reset_dout", dout, 256'd0);
        check("reset_ack1", 256'(ack1), 256'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_req($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                    vecs[i].drop, vecs[i].exp_dout);
        end

        // Reset five cycles into a write of 0xFF to line 7.
        @(negedge clk);
        en = 1'b1; wr = 1'b1; addr = 32'h0000_00E0; wdata = 256'hFF;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_ack", 256'(ack), 256'd0);
        check("rst_mid_dout", dout, 256'd0);
        en = 1'b0; wr = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        run_req("post_rst_read", 1'b0, 32'h0000_00E0, 256'd0, 1'b0, 256'h77);

        // LATENCY=1 with enable held: ack every third edge.
        @(negedge clk);
        en1 = 1'b1;
        last = -2;
        acks = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #1;
            if (ack1) begin
                check("l1_gap", 256'(n - last), 256'd3);
                last = n;
                acks++;
            end
        end
        en1 = 1'b0;
        check("l1_count", 256'(acks), 256'd10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
